// File: rtl/pulse_period_monitor.sv
// Receiving side of the periodic-pulse link: measures pulse spacing, locks after
// a run of well-spaced pulses, and flags early or missing pulses.
module pulse_period_monitor #(
  parameter int N        = 7500,
  parameter int CBITS    = 13,
  parameter int TOL      = 0,
  parameter int LOCK_CNT = 4,
  parameter int ECBITS   = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              sig,
  output logic              locked,
  output logic              early_err,
  output logic              late_err,
  output logic [CBITS-1:0]  last_period,
  output logic [ECBITS-1:0] err_cnt
);

  localparam int GW = $clog2(LOCK_CNT + 1);
  localparam logic [CBITS-1:0] LO       = CBITS'(N + 1 - TOL);
  localparam logic [CBITS-1:0] HI       = CBITS'(N + 1 + TOL);
  localparam logic [GW-1:0]    GOOD_MAX = GW'(LOCK_CNT);

  typedef enum logic [1:0] {IDLE, TRACK, LOCKED} state_t;

  state_t             state_q, state_d;
  logic [CBITS-1:0]   iv_q, iv_d;
  logic [CBITS-1:0]   last_q, last_d;
  logic [GW-1:0]      good_q, good_d;
  logic               locked_q, locked_d;
  logic               early_q, early_d;
  logic               late_q, late_d;
  logic [ECBITS-1:0]  errc_q, errc_d;
  logic               pulse_good, pulse_early, timeout;

  always_comb begin
    pulse_good  = sig && (iv_q >= LO) && (iv_q <= HI);
    pulse_early = sig && (iv_q < LO);
    // A pulse landing exactly on the last allowed cycle beats the timeout.
    timeout     = !sig && (iv_q == HI);

    state_d = state_q;
    good_d  = good_q;
    last_d  = last_q;
    early_d = 1'b0;
    late_d  = 1'b0;

    if (sig)         iv_d = CBITS'(1);
    else if (&iv_q)  iv_d = iv_q;
    else             iv_d = iv_q + CBITS'(1);

    case (state_q)
      IDLE: begin
        if (sig) begin
          state_d = TRACK;
          good_d  = '0;
        end
      end
      TRACK: begin
        if (pulse_good) begin
          last_d = iv_q;
          good_d = good_q + GW'(1);
          if (good_q + GW'(1) == GOOD_MAX) state_d = LOCKED;
        end else if (pulse_early) begin
          early_d = 1'b1;
          good_d  = '0;
          last_d  = iv_q;
        end else if (timeout) begin
          late_d  = 1'b1;
          good_d  = '0;
          state_d = IDLE;
        end
      end
      LOCKED: begin
        if (pulse_good) begin
          last_d = iv_q;
        end else if (pulse_early) begin
          early_d = 1'b1;
          last_d  = iv_q;
          good_d  = '0;
          state_d = TRACK;
        end else if (timeout) begin
          late_d  = 1'b1;
          good_d  = '0;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

    locked_d = (state_d == LOCKED);
    errc_d   = errc_q;
    if ((early_d || late_d) && !(&errc_q)) errc_d = errc_q + ECBITS'(1);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= IDLE;
      iv_q     <= '0;
      good_q   <= '0;
      last_q   <= '0;
      locked_q <= 1'b0;
      early_q  <= 1'b0;
      late_q   <= 1'b0;
      errc_q   <= '0;
    end else begin
      state_q  <= state_d;
      iv_q     <= iv_d;
      good_q   <= good_d;
      last_q   <= last_d;
      locked_q <= locked_d;
      early_q  <= early_d;
      late_q   <= late_d;
      errc_q   <= errc_d;
    end
  end

  assign locked      = locked_q;
  assign early_err   = early_q;
  assign late_err    = late_q;
  assign last_period = last_q;
  assign err_cnt     = errc_q;

endmodule

// File: tb/tb_pulse_period_monitor.sv
// Scenario bench for pulse_period_monitor: every cycle is compared against a
// behavioural model of the pulse-spacing rules, plus fixed expectations per scenario.
module tb_pulse_period_monitor;
  localparam int N = 10, CBITS = 5, TOL = 1, LOCK_CNT = 3, ECBITS = 4;
  localparam int P = N + 1;
  localparam int OW = 3 + CBITS + ECBITS;

  logic clk = 1'b0, rst = 1'b0, sig = 1'b0;
  logic locked, early_err, late_err;
  logic [CBITS-1:0]  last_period;
  logic [ECBITS-1:0] err_cnt;

  int n_chk = 0, n_fail = 0;

  typedef enum {M_IDLE, M_TRACK, M_LOCKED} mmode_t;
  mmode_t m_mode;
  int m_since, m_run, m_last, m_err;
  bit m_early, m_late;
  bit pat[$];

  always #5 clk = ~clk;

  pulse_period_monitor #(.N(N), .CBITS(CBITS), .TOL(TOL), .LOCK_CNT(LOCK_CNT), .ECBITS(ECBITS)) dut (
    .clk(clk), .rst(rst), .sig(sig), .locked(locked), .early_err(early_err),
    .late_err(late_err), .last_period(last_period), .err_cnt(err_cnt));

  wire  [OW-1:0] obs = {locked, early_err, late_err, last_period, err_cnt};
  logic [OW-1:0] exp_v;
  assign exp_v = {m_mode == M_LOCKED, m_early, m_late, CBITS'(m_last), ECBITS'(m_err)};

  task automatic model_reset();
    m_mode = M_IDLE; m_since = 0; m_run = 0; m_last = 0; m_err = 0;
    m_early = 0; m_late = 0;
  endtask

  // One clock edge of the pulse-spacing rules, m_since = cycles since last accepted pulse.
  task automatic model_edge(input bit s);
    m_early = 0; m_late = 0;
    if (m_mode == M_IDLE) begin
      if (s) begin m_mode = M_TRACK; m_run = 0; end
    end else if (s) begin
      m_last = m_since;
      if (m_since >= P - TOL && m_since <= P + TOL) begin
        if (m_mode == M_TRACK) begin
          m_run++;
          if (m_run == LOCK_CNT) m_mode = M_LOCKED;
        end
      end else begin
        m_early = 1; m_run = 0; m_mode = M_TRACK;
      end
    end else if (m_since == P + TOL) begin
      m_late = 1; m_run = 0; m_mode = M_IDLE;
    end
    if ((m_early || m_late) && m_err < 2**ECBITS - 1) m_err++;
    m_since = s ? 1 : m_since + 1;
  endtask

  task automatic step(input bit s);
    sig = s;
    @(posedge clk);
    if (rst) model_edge(s);
    #1;
  endtask

  task automatic add_gap(input int k);
    repeat (k - 1) pat.push_back(1'b0);
    pat.push_back(1'b1);
  endtask

  task automatic test_reset();
    n_chk++;
    if (obs !== '0) begin n_fail++; $display("FAIL reset_vals: got %h want 0", obs); end
    rst = 1'b1;
  endtask

  task automatic test_lock();
    bit lk_before = 1'b1;
    pat.delete(); pat.push_back(1'b1);
    repeat (3) add_gap(P);
    foreach (pat[i]) begin
      step(pat[i]); n_chk++;
      if (obs !== exp_v) begin n_fail++; $display("FAIL lock cyc%0d: got %h want %h", i, obs, exp_v); end
      if (i == pat.size() - 2) lk_before = locked;
    end
    n_chk++;
    if (lk_before !== 1'b0 || locked !== 1'b1 || last_period !== 5'd11 || err_cnt !== 4'd0) begin
      n_fail++; $display("FAIL lock_end: lk_before=%b locked=%b last=%0d err=%0d want 0 1 11 0",
                         lk_before, locked, last_period, err_cnt);
    end
  endtask

  task automatic test_early();
    int n_e = 0;
    pat.delete(); add_gap(8);
    foreach (pat[i]) begin
      step(pat[i]); n_chk++;
      if (obs !== exp_v) begin n_fail++; $display("FAIL early cyc%0d: got %h want %h", i, obs, exp_v); end
      if (early_err) n_e++;
    end
    n_chk++;
    if (n_e != 1 || locked !== 1'b0 || err_cnt !== 4'd1 || last_period !== 5'd8) begin
      n_fail++; $display("FAIL early_end: n_e=%0d locked=%b err=%0d last=%0d want 1 0 1 8",
                         n_e, locked, err_cnt, last_period);
    end
    pat.delete(); repeat (3) add_gap(P);
    foreach (pat[i]) begin
      step(pat[i]); n_chk++;
      if (obs !== exp_v) begin n_fail++; $display("FAIL relock cyc%0d: got %h want %h", i, obs, exp_v); end
    end
    n_chk++;
    if (locked !== 1'b1) begin n_fail++; $display("FAIL relock_end: locked=%b want 1", locked); end
  endtask

  task automatic test_late();
    int late_idx = -1, n_l = 0;
    pat.delete(); repeat (14) pat.push_back(1'b0);
    foreach (pat[i]) begin
      step(pat[i]); n_chk++;
      if (obs !== exp_v) begin n_fail++; $display("FAIL late cyc%0d: got %h want %h", i, obs, exp_v); end
      if (late_err) begin n_l++; if (late_idx < 0) late_idx = i; end
    end
    // Pulse sampled on edge 0; late visible after edge 12 (loop index 11).
    n_chk++;
    if (late_idx != 11 || n_l != 1 || locked !== 1'b0 || err_cnt !== 4'd2) begin
      n_fail++; $display("FAIL late_end: idx=%0d n=%0d locked=%b err=%0d want 11 1 0 2",
                         late_idx, n_l, locked, err_cnt);
    end
    step(1'b1); n_chk++;
    if (early_err !== 1'b0 || late_err !== 1'b0 || err_cnt !== 4'd2 || last_period !== 5'd11) begin
      n_fail++; $display("FAIL rearm: e=%b l=%b err=%0d last=%0d want 0 0 2 11",
                         early_err, late_err, err_cnt, last_period);
    end
  endtask

  task automatic test_window();
    int n_l = 0;
    pat.delete(); add_gap(10); add_gap(12); add_gap(12);
    foreach (pat[i]) begin
      step(pat[i]); n_chk++;
      if (obs !== exp_v) begin n_fail++; $display("FAIL window cyc%0d: got %h want %h", i, obs, exp_v); end
    end
    n_chk++;
    if (locked !== 1'b1 || last_period !== 5'd12 || err_cnt !== 4'd2) begin
      n_fail++; $display("FAIL window_end: locked=%b last=%0d err=%0d want 1 12 2", locked, last_period, err_cnt);
    end
    pat.delete(); add_gap(13);
    foreach (pat[i]) begin
      step(pat[i]); n_chk++;
      if (obs !== exp_v) begin n_fail++; $display("FAIL gap13 cyc%0d: got %h want %h", i, obs, exp_v); end
      if (late_err) begin
        n_l++;
        n_chk++;
        if (i != 11) begin n_fail++; $display("FAIL gap13_when: late at idx %0d want 11", i); end
      end
    end
    n_chk++;
    if (n_l != 1 || locked !== 1'b0 || err_cnt !== 4'd3 || last_period !== 5'd12) begin
      n_fail++; $display("FAIL gap13_end: n=%0d locked=%b err=%0d last=%0d want 1 0 3 12",
                         n_l, locked, err_cnt, last_period);
    end
  endtask

  task automatic test_hold();
    int n_e = 0;
    pat.delete(); repeat (3) add_gap(P);
    foreach (pat[i]) begin
      step(pat[i]); n_chk++;
      if (obs !== exp_v) begin n_fail++; $display("FAIL hold_lock cyc%0d: got %h want %h", i, obs, exp_v); end
    end
    pat.delete(); add_gap(P); pat.push_back(1'b1); pat.push_back(1'b1);
    foreach (pat[i]) begin
      step(pat[i]); n_chk++;
      if (obs !== exp_v) begin n_fail++; $display("FAIL hold cyc%0d: got %h want %h", i, obs, exp_v); end
      if (early_err) n_e++;
    end
    n_chk++;
    if (n_e != 2 || err_cnt !== 4'd5 || last_period !== 5'd1 || locked !== 1'b0) begin
      n_fail++; $display("FAIL hold_end: n_e=%0d err=%0d last=%0d locked=%b want 2 5 1 0",
                         n_e, err_cnt, last_period, locked);
    end
    pat.delete(); repeat (20) pat.push_back(1'b1);
    foreach (pat[i]) begin
      step(pat[i]); n_chk++;
      if (obs !== exp_v) begin n_fail++; $display("FAIL sat cyc%0d: got %h want %h", i, obs, exp_v); end
    end
    n_chk++;
    if (err_cnt !== 4'd15) begin n_fail++; $display("FAIL sat_end: err=%0d want 15", err_cnt); end
  endtask

  task automatic test_async_reset();
    bit lk_before = 1'b1;
    pat.delete(); repeat (3) add_gap(P); repeat (5) pat.push_back(1'b0);
    foreach (pat[i]) begin
      step(pat[i]); n_chk++;
      if (obs !== exp_v) begin n_fail++; $display("FAIL pre_rst cyc%0d: got %h want %h", i, obs, exp_v); end
    end
    #3 rst = 1'b0;
    #1 model_reset();
    n_chk++;
    if (obs !== '0) begin n_fail++; $display("FAIL async_rst: got %h want 0", obs); end
    step(1'b1); step(1'b0);
    n_chk++;
    if (obs !== '0) begin n_fail++; $display("FAIL held_rst: got %h want 0", obs); end
    rst = 1'b1;
    pat.delete(); pat.push_back(1'b1); repeat (3) add_gap(P);
    foreach (pat[i]) begin
      step(pat[i]); n_chk++;
      if (obs !== exp_v) begin n_fail++; $display("FAIL post_rst cyc%0d: got %h want %h", i, obs, exp_v); end
      if (i == pat.size() - 2) lk_before = locked;
    end
    n_chk++;
    if (lk_before !== 1'b0 || locked !== 1'b1 || err_cnt !== 4'd0) begin
      n_fail++; $display("FAIL post_rst_end: lk_before=%b locked=%b err=%0d want 0 1 0",
                         lk_before, locked, err_cnt);
    end
  endtask

  task automatic test_random();
    pat.delete();
    for (int k = 0; k < 200; k++) begin
      if ($urandom_range(0, 9) < 7) add_gap($urandom_range(P - TOL, P + TOL));
      else                          add_gap($urandom_range(1, P + TOL + 3));
    end
    foreach (pat[i]) begin
      step(pat[i]); n_chk++;
      if (obs !== exp_v) begin n_fail++; $display("FAIL random cyc%0d: got %h want %h", i, obs, exp_v); end
    end
  endtask

  initial begin
    model_reset();
    rst = 1'b0; sig = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    test_reset();
    test_lock();
    test_early();
    test_late();
    test_window();
    test_hold();
    test_async_reset();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
